// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle ops, iterative MUL/DIV, memory-operand add
// Outputs other than Busy/Done/MemReq/MemAddr are registered on entry to DONE.
module seq_alu #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             MemReq,
  output logic [WIDTH-1:0] MemAddr,
  input  logic [WIDTH-1:0] MemData,
  input  logic             ValidMemData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       Flags,
  output logic             Err
);

  localparam int SH_W    = $clog2(WIDTH);
  localparam int CNT_MAX = (WIDTH > MEM_TIMEOUT) ? WIDTH : MEM_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_LDADD = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_ITER,
    ST_MEMWAIT,
    ST_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic             last_iter;
  logic             mem_expired;

  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
  assign mem_expired = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Single-cycle datapath
  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] exec_res;
  logic [WIDTH-1:0] exec_hi;
  logic             exec_c;
  logic             exec_v;
  logic             exec_err;
  logic             exec_undef;
  logic [3:0]       exec_flags;

  assign shamt = b_q[SH_W-1:0];
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  // The extra bit on each side catches the last bit shifted out (zero for a zero shift).
  assign shl_w = {1'b0, a_q} << shamt;
  assign shr_w = {a_q, 1'b0} >> shamt;

  always_comb begin
    exec_res   = '0;
    exec_hi    = '0;
    exec_c     = 1'b0;
    exec_v     = 1'b0;
    exec_err   = 1'b0;
    exec_undef = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = add_w[WIDTH-1:0];
        exec_c   = add_w[WIDTH];
        exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = sub_w[WIDTH-1:0];
        exec_c   = ~sub_w[WIDTH];
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SHL: begin
        exec_res = shl_w[WIDTH-1:0];
        exec_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        exec_res = shr_w[WIDTH:1];
        exec_c   = shr_w[0];
      end
      OP_MUL: exec_res = '0;
      OP_DIV: begin
        exec_res = '1;
        exec_hi  = a_q;
        exec_err = 1'b1;
      end
      default: begin
        exec_err   = 1'b1;
        exec_undef = 1'b1;
      end
    endcase
    exec_flags = exec_undef ? 4'b0000 : {exec_res[WIDTH-1], (exec_res == '0), exec_c, exec_v};
  end

  // One shift-add or restoring-divide step per ITER cycle
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fit;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [3:0]       iter_flags;

  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {work_hi, work_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_fit   = (div_shift >= {1'b0, b_q});

  always_comb begin
    step_hi    = '0;
    step_lo    = '0;
    iter_flags = '0;
    if (op_q == OP_MUL) begin
      {step_hi, step_lo} = {mul_sum, work_lo[WIDTH-1:1]};
    end else begin
      step_hi = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], div_fit};
    end
    iter_flags[3] = step_lo[WIDTH-1];
    iter_flags[2] = (step_lo == '0);
    if (op_q == OP_MUL) begin
      iter_flags[1] = (step_hi != '0);
      iter_flags[0] = (step_hi != '0);
    end
  end

  logic [WIDTH:0] ld_sum;
  logic           ld_v;
  logic [3:0]     ld_flags;

  assign ld_sum   = {1'b0, a_q} + {1'b0, MemData};
  assign ld_v     = (a_q[WIDTH-1] == MemData[WIDTH-1]) && (ld_sum[WIDTH-1] != a_q[WIDTH-1]);
  assign ld_flags = {ld_sum[WIDTH-1], (ld_sum[WIDTH-1:0] == '0), ld_sum[WIDTH], ld_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (((Op == OP_MUL) || (Op == OP_DIV)) && (B != '0)) begin
            state_d = ST_ITER;
          end else if (Op == OP_LDADD) begin
            state_d = ST_MEMWAIT;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC:    state_d = ST_DONE;
      ST_ITER:    if (last_iter) state_d = ST_DONE;
      ST_MEMWAIT: if (ValidMemData || mem_expired) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            op_q    <= Op;
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= '0;
            work_hi <= '0;
            work_lo <= (Op == OP_DIV) ? A : B;
            err_q   <= 1'b0;
          end
        end
        ST_EXEC: begin
          res_q    <= exec_res;
          res_hi_q <= exec_hi;
          flags_q  <= exec_flags;
          err_q    <= exec_err;
        end
        ST_ITER: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          work_hi <= step_hi;
          work_lo <= step_lo;
          if (last_iter) begin
            res_q    <= step_lo;
            res_hi_q <= step_hi;
            flags_q  <= iter_flags;
            err_q    <= 1'b0;
          end
        end
        ST_MEMWAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (ValidMemData) begin
            res_q    <= ld_sum[WIDTH-1:0];
            res_hi_q <= '0;
            flags_q  <= ld_flags;
            err_q    <= 1'b0;
          end else if (mem_expired) begin
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_DONE);
  assign MemReq   = (state_q == ST_MEMWAIT);
  assign MemAddr  = MemReq ? b_q : '0;
  assign Result   = res_q;
  assign ResultHi = res_hi_q;
  assign Flags    = flags_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu against a behavioural model
module tb_seq_alu;

  localparam int W   = 32;
  localparam int TMO = 16;

  localparam logic [3:0] T_ADD = 4'd0;
  localparam logic [3:0] T_SUB = 4'd1;
  localparam logic [3:0] T_SHL = 4'd5;
  localparam logic [3:0] T_SHR = 4'd6;
  localparam logic [3:0] T_MUL = 4'd7;
  localparam logic [3:0] T_DIV = 4'd8;
  localparam logic [3:0] T_LD  = 4'd9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [3:0]   Op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] MemData = '0;
  logic         ValidMemData = 1'b0;
  logic         MemReq;
  logic [W-1:0] MemAddr;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic [3:0]   Flags;
  logic         Err;

  seq_alu #(.WIDTH(W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .ValidMemData(ValidMemData),
    .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi), .Flags(Flags), .Err(Err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected results straight from the arithmetic definitions.
  function automatic void compute(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] hi,
                                  output logic [3:0] f, output logic e);
    longint sa, sb, s, lim_hi, lim_lo;
    logic [2*W-1:0] p;
    int sh;
    logic c, v;
    lim_hi = 2147483647;
    lim_lo = -lim_hi - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[$clog2(W)-1:0]);
    r = '0; hi = '0; f = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'd0: begin
        p = {32'b0, a} + {32'b0, b};
        r = p[W-1:0]; c = p[W];
        s = sa + sb; v = (s > lim_hi) || (s < lim_lo);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s > lim_hi) || (s < lim_lo);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << sh; c = (sh != 0) ? a[W-sh] : 1'b0; end
      4'd6: begin r = a >> sh; c = (sh != 0) ? a[sh-1] : 1'b0; end
      4'd7: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[W-1:0]; hi = p[2*W-1:W]; c = (hi != 0); v = c;
      end
      4'd8: begin
        if (b == 0) begin e = 1'b1; r = '1; hi = a; end
        else begin r = a / b; hi = a % b; end
      end
      default: begin e = 1'b1; return; end
    endcase
    f = {r[W-1], (r == 0), c, v};
  endfunction

  // Cycle-level behavioural model: busy window length, memory handshake, published results.
  logic         m_busy = 1'b0, m_done = 1'b0, m_mem = 1'b0, m_err = 1'b0, p_err = 1'b0;
  logic [W-1:0] m_res = '0, m_hi = '0, m_addr = '0, m_a = '0, p_res = '0, p_hi = '0;
  logic [3:0]   m_flags = '0, p_flags = '0;
  int           m_left = 0, m_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_mem = 0; m_err = 0;
      m_res = '0; m_hi = '0; m_flags = '0; m_addr = '0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (Start) begin
        m_busy = 1; m_err = 0;
        if (Op == T_LD) begin
          m_mem = 1; m_cnt = 0; m_a = A; m_addr = B;
        end else begin
          compute(Op, A, B, p_res, p_hi, p_flags, p_err);
          m_left = (((Op == T_MUL) || (Op == T_DIV)) && (B != 0)) ? W : 1;
        end
      end
    end else if (m_mem) begin
      if (ValidMemData) begin
        compute(T_ADD, m_a, MemData, p_res, p_hi, p_flags, p_err);
        m_res = p_res; m_hi = p_hi; m_flags = p_flags; m_err = p_err;
        m_mem = 0; m_done = 1;
      end else begin
        m_cnt++;
        if (m_cnt == TMO) begin
          m_res = '0; m_hi = '0; m_flags = '0; m_err = 1;
          m_mem = 0; m_done = 1;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_res = p_res; m_hi = p_hi; m_flags = p_flags; m_err = p_err;
        m_done = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", Busy, m_busy);
    chk("done", Done, m_done);
    chk("memreq", MemReq, m_mem);
    chk("memaddr", MemAddr, m_mem ? m_addr : '0);
    chk("result", Result, m_res);
    chk("result_hi", ResultHi, m_hi);
    chk("flags", Flags, m_flags);
    chk("err", Err, m_err);
  end

  logic [W-1:0] g_res, g_hi;
  logic [3:0]   g_flags;
  logic         g_err, g_memreq_done, g_done_next;
  int           g_lat, g_busy, g_memcyc;

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_memreq"}, MemReq, 0);
    chk({tag, "_memaddr"}, MemAddr, 0);
    chk({tag, "_result"}, Result, 0);
    chk({tag, "_result_hi"}, ResultHi, 0);
    chk({tag, "_flags"}, Flags, 0);
    chk({tag, "_err"}, Err, 0);
  endtask

  // mem_delay: raise ValidMemData once MemReq has been seen that many cycles (0 = never)
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int mem_delay, input logic [W-1:0] mdata);
    bit seen;
    seen = 0; g_lat = 0; g_busy = 0; g_memcyc = 0;
    @(negedge clk);
    Start = 1; Op = op; A = a; B = b; ValidMemData = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (Busy) g_busy++;
      if (MemReq) g_memcyc++;
      if (Done) begin
        seen = 1; g_lat = k;
        g_res = Result; g_hi = ResultHi; g_flags = Flags; g_err = Err; g_memreq_done = MemReq;
        break;
      end
      if (op == T_LD) begin
        ValidMemData = MemReq && (g_memcyc == mem_delay);
        MemData = ValidMemData ? mdata : $urandom;
      end else begin
        ValidMemData = 1'($urandom_range(0, 1));
        MemData = $urandom;
      end
      Start = 1'($urandom_range(0, 1)); Op = 4'($urandom); A = $urandom; B = $urandom;
    end
    chk("done_seen", 32'(seen), 1);
    Start = 1; Op = 4'($urandom); A = $urandom; B = $urandom;
    @(negedge clk);
    g_done_next = Done;
    Start = 0; ValidMemData = 0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return W'($urandom_range(0, 255));
      2: return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      default: return 32'h8000_0000 ^ W'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [W-1:0] r, hi, ra, rb;
    logic [3:0]   f, rop;
    logic         e;
    int           n_done, rd;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;

    compute(T_ADD, 32'hFFFF_FFFF, 32'd1, r, hi, f, e);
    chk("model_add_res", r, 0);
    chk("model_add_flags", f, 4'b0110);
    compute(T_SUB, 32'd3, 32'd5, r, hi, f, e);
    chk("model_sub_res", r, 32'hFFFF_FFFE);
    chk("model_sub_flags", f, 4'b1000);
    compute(T_MUL, 32'h0001_0000, 32'h0001_0000, r, hi, f, e);
    chk("model_mul_hi", hi, 1);
    chk("model_mul_flags", f, 4'b0111);

    do_op(T_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0);
    chk("add_lat", g_lat, 2);
    chk("add_res", g_res, 0);
    chk("add_flags", g_flags, 4'b0110);

    do_op(T_MUL, 32'd879199, 32'd5, 0, 0);
    chk("mul_res", g_res, 32'd4395995);
    chk("mul_hi", g_hi, 0);
    chk("mul_cv", g_flags[1:0], 0);
    chk("mul_lat", g_lat, 33);
    chk("mul_busy", g_busy, 33);
    chk("mul_single_done", g_done_next, 0);

    do_op(T_DIV, 32'd100, 32'd7, 0, 0);
    chk("div_res", g_res, 14);
    chk("div_rem", g_hi, 2);
    chk("div_err", g_err, 0);
    chk("div_lat", g_lat, 33);

    do_op(T_DIV, 32'd9, 32'd0, 0, 0);
    chk("div0_err", g_err, 1);
    chk("div0_res", g_res, 32'hFFFF_FFFF);
    chk("div0_rem", g_hi, 9);
    chk("div0_lat", g_lat, 2);

    do_op(T_SHL, 32'h8000_0001, 32'd1, 0, 0);
    chk("shl_res", g_res, 2);
    chk("shl_flags", g_flags, 4'b0010);
    do_op(T_SHR, 32'h8000_0003, 32'd32, 0, 0);
    chk("shr0_res", g_res, 32'h8000_0003);
    chk("shr0_flags", g_flags, 4'b1000);
    do_op(T_SUB, 32'h8000_0000, 32'd1, 0, 0);
    chk("sub_ovf_res", g_res, 32'h7FFF_FFFF);
    chk("sub_ovf_flags", g_flags, 4'b0011);
    do_op(4'd12, 32'd5, 32'd6, 0, 0);
    chk("undef_err", g_err, 1);
    chk("undef_res", g_res, 0);
    chk("undef_flags", g_flags, 0);

    do_op(T_LD, 32'd879199, 32'h100, 8, 32'd500);
    chk("ld_res", g_res, 32'd879699);
    chk("ld_memcyc", g_memcyc, 8);
    chk("ld_memreq_at_done", g_memreq_done, 0);
    chk("ld_lat", g_lat, 9);

    do_op(T_LD, 32'd1234, 32'h200, 0, 0);
    chk("tmo_memcyc", g_memcyc, TMO);
    chk("tmo_lat", g_lat, TMO + 1);
    chk("tmo_err", g_err, 1);
    chk("tmo_res", g_res, 0);
    ValidMemData = 1; MemData = 32'd77;
    @(negedge clk);
    ValidMemData = 0;
    repeat (2) @(negedge clk);
    chk("late_valid_res", Result, 0);
    chk("late_valid_err", Err, 1);
    chk("late_valid_busy", Busy, 0);

    @(negedge clk);
    Start = 1; Op = T_MUL; A = 32'd879199; B = 32'd5;
    @(negedge clk);
    Start = 0;
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_zero("midrst");
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (Done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    rst_n = 1;
    do_op(T_ADD, 32'd2, 32'd3, 0, 0);
    chk("post_rst_res", g_res, 5);
    chk("post_rst_lat", g_lat, 2);

    for (int i = 0; i < 300; i++) begin
      rd = $urandom_range(0, 19);
      rop = (rd < 16) ? 4'(rd) : 4'(rd - 10);
      ra = rnd_operand();
      rb = rnd_operand();
      if (((rop == T_MUL) || (rop == T_DIV)) && ($urandom_range(0, 3) == 0)) rb = '0;
      do_op(rop, ra, rb, $urandom_range(1, 20), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
